// File: rtl/demux_3_route_pkg.sv
// Shared definitions for the 3-way routing demux.
//   DATA_W / CNT_W  : routed word width and delivery counter width
//   sel_t           : in_select encodings (three channels plus one invalid code)
//   slot_state_t    : single-entry slot occupancy
//   sat_inc()       : saturating counter increment
package demux_3_route_pkg;

  localparam int DATA_W = 24;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    SEL_CH0 = 2'b00,
    SEL_CH1 = 2'b01,
    SEL_CH2 = 2'b10,
    SEL_BAD = 2'b11
  } sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux_3_route_if.sv
// Handshake bundle for demux_3_route.
// Handshake rule (both sides): a word moves on a rising clk edge exactly when
// valid and ready are both 1 in that cycle. ready never depends on valid, and a
// holder keeps its data stable while valid=1 and ready=0.
//   in_valid/in_ready/in_data/in_select : source side
//   out_valid[k]/out_ready[k]/out_data_k : destination k side
// Modports: master = environment (source + destinations), slave = the demux.
interface demux_3_route_if;
  import demux_3_route_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_select;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready;
  logic [DATA_W-1:0] out_data_0;
  logic [DATA_W-1:0] out_data_1;
  logic [DATA_W-1:0] out_data_2;

  modport master (
    output in_valid, in_data, in_select, out_ready,
    input  in_ready, out_valid, out_data_0, out_data_1, out_data_2
  );

  modport slave (
    input  in_valid, in_data, in_select, out_ready,
    output in_ready, out_valid, out_data_0, out_data_1, out_data_2
  );

endinterface

// File: rtl/demux_3_route_slot.sv
// route_slot: one single-entry output buffer with a saturating delivery counter.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous counter clear (held word is kept)
//   load     : a word is being taken into this slot this cycle
//   ready    : destination accepts the held word this cycle
//   din      : word to load
//   space    : slot can accept a word this cycle (empty, or draining)
//   valid    : slot holds a word
//   dout     : held word (keeps last value when empty)
//   cnt      : words delivered, saturating
//   state    : slot occupancy, exposed for observation
module route_slot
  import demux_3_route_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              ready,
  input  logic [DATA_W-1:0] din,
  output logic              space,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  cnt,
  output slot_state_t       state
);

  logic pop;

  assign valid = (state == FULL);
  assign pop   = valid & ready;
  // A full slot being drained this cycle can take a new word at the same edge.
  assign space = (state == EMPTY) | ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      dout  <= '0;
      cnt   <= '0;
    end else begin
      if (clear) begin
        cnt <= '0;
      end else if (pop) begin
        cnt <= sat_inc(cnt);
      end

      // load is only asserted by the parent when space=1, so load while FULL
      // always coincides with a pop: replace the word and stay FULL.
      unique case (state)
        EMPTY: begin
          if (load) begin
            dout  <= din;
            state <= FULL;
          end
        end
        FULL: begin
          if (load) begin
            dout <= din;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/demux_3_route.sv
// demux_3_route: routes each accepted input word to one of three single-entry
// output slots selected by in_select; the invalid select code drops the word,
// counts it and raises a sticky error flag.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous clear of all counters and sel_err
//   bus        : handshake bundle (slave side)
//   cnt_0..2   : words delivered per channel (saturating)
//   drop_cnt   : words accepted with the invalid select (saturating)
//   sel_err    : sticky invalid-select flag
//   slot_state : occupancy of slots 2..0 (1 = FULL), for observation
module demux_3_route
  import demux_3_route_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  demux_3_route_if.slave    bus,
  output logic [CNT_W-1:0]  cnt_0,
  output logic [CNT_W-1:0]  cnt_1,
  output logic [CNT_W-1:0]  cnt_2,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              sel_err,
  output logic [2:0]        slot_state
);

  logic [2:0]  space;
  logic [2:0]  load;
  logic        take;
  logic        drop;
  slot_state_t st_0, st_1, st_2;

  // in_ready depends only on select and slot/destination status, never on
  // in_valid. Slots are forced EMPTY by reset, the rst term just makes the
  // reset-time value explicit.
  always_comb begin
    bus.in_ready = 1'b1;
    unique case (bus.in_select)
      SEL_CH0: bus.in_ready = space[0];
      SEL_CH1: bus.in_ready = space[1];
      SEL_CH2: bus.in_ready = space[2];
      SEL_BAD: bus.in_ready = 1'b1;
      default: bus.in_ready = 1'b1;
    endcase
    bus.in_ready = bus.in_ready | rst;
  end

  assign take    = bus.in_valid & bus.in_ready;
  assign load[0] = take & (bus.in_select == SEL_CH0);
  assign load[1] = take & (bus.in_select == SEL_CH1);
  assign load[2] = take & (bus.in_select == SEL_CH2);
  assign drop    = take & (bus.in_select == SEL_BAD);

  route_slot u_slot_0 (
    .clk(clk), .rst(rst), .clear(clear), .load(load[0]), .ready(bus.out_ready[0]),
    .din(bus.in_data), .space(space[0]), .valid(bus.out_valid[0]),
    .dout(bus.out_data_0), .cnt(cnt_0), .state(st_0)
  );

  route_slot u_slot_1 (
    .clk(clk), .rst(rst), .clear(clear), .load(load[1]), .ready(bus.out_ready[1]),
    .din(bus.in_data), .space(space[1]), .valid(bus.out_valid[1]),
    .dout(bus.out_data_1), .cnt(cnt_1), .state(st_1)
  );

  route_slot u_slot_2 (
    .clk(clk), .rst(rst), .clear(clear), .load(load[2]), .ready(bus.out_ready[2]),
    .din(bus.in_data), .space(space[2]), .valid(bus.out_valid[2]),
    .dout(bus.out_data_2), .cnt(cnt_2), .state(st_2)
  );

  assign slot_state = {st_2 == FULL, st_1 == FULL, st_0 == FULL};

  // clear wins over a coincident invalid take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      sel_err  <= 1'b0;
    end else if (clear) begin
      drop_cnt <= '0;
      sel_err  <= 1'b0;
    end else if (drop) begin
      drop_cnt <= sat_inc(drop_cnt);
      sel_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_3_route.sv
// Self-checking bench for demux_3_route: a constant vector table, hand-written
// corner sequences (saturation, mid-transfer reset) and randomized traffic,
// all compared against a queue-based reference model.
module tb_demux_3_route;
  import demux_3_route_pkg::*;

  localparam int MAXC = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic [CNT_W-1:0] cnt_0, cnt_1, cnt_2, drop_cnt;
  logic             sel_err;
  logic [2:0]       slot_state;

  demux_3_route_if bus();

  demux_3_route dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus.slave),
    .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2),
    .drop_cnt(drop_cnt), .sel_err(sel_err), .slot_state(slot_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;

  // Per-channel queue of words waiting for delivery (capacity one by the rules).
  logic [DATA_W-1:0] exp_q [3][$];
  logic [DATA_W-1:0] m_last [3];
  int                m_cnt [3];
  int                m_drop;
  bit                m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_of(input int k);
    case (k)
      0:       return bus.out_data_0;
      1:       return bus.out_data_1;
      default: return bus.out_data_2;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(input int k);
    case (k)
      0:       return cnt_0;
      1:       return cnt_1;
      default: return cnt_2;
    endcase
  endfunction

  function automatic bit model_ready(input logic [1:0] sel, input logic [2:0] ordy);
    if (sel == 2'b11) return 1'b1;
    return (exp_q[int'(sel)].size() == 0) || ordy[sel];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      m_last[k] = '0;
      m_cnt[k]  = 0;
    end
    m_drop = 0;
    m_err  = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [2:0] v;
    for (int k = 0; k < 3; k++) begin
      v[k] = (exp_q[k].size() != 0);
      check($sformatf("%s data_%0d", tag, k), data_of(k), m_last[k]);
      check($sformatf("%s cnt_%0d", tag, k), cnt_of(k), m_cnt[k]);
    end
    check({tag, " out_valid"}, bus.out_valid, v);
    check({tag, " slot_state"}, slot_state, v);
    check({tag, " drop_cnt"}, drop_cnt, m_drop);
    check({tag, " sel_err"}, sel_err, m_err);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drive, sample in_ready, cross the edge, check state.
  task automatic cycle(input bit iv, input logic [1:0] sel, input logic [DATA_W-1:0] d,
                       input logic [2:0] ordy, input bit clr, output bit rdy);
    bit         take;
    logic [2:0] pops;
    bus.in_valid  = iv;
    bus.in_select = sel;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clear         = clr;
    #1;
    rdy = bus.in_ready;
    check("in_ready", rdy, model_ready(sel, ordy));
    take = iv && model_ready(sel, ordy);
    for (int k = 0; k < 3; k++) begin
      pops[k] = (exp_q[k].size() != 0) && ordy[k];
      if (pops[k]) check($sformatf("pop_word_%0d", k), data_of(k), exp_q[k][0]);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (pops[k]) begin
        void'(exp_q[k].pop_front());
        m_cnt[k] = (m_cnt[k] < MAXC) ? m_cnt[k] + 1 : MAXC;
      end
      if (clr) m_cnt[k] = 0;
    end
    if (take && sel != 2'b11) begin
      exp_q[int'(sel)].push_back(d);
      m_last[int'(sel)] = d;
    end
    if (clr) begin
      m_drop = 0;
      m_err  = 1'b0;
    end else if (take && sel == 2'b11) begin
      m_drop = (m_drop < MAXC) ? m_drop + 1 : MAXC;
      m_err  = 1'b1;
    end
    #1;
    check_state("cyc");
  endtask

  // 1 ns reset pulse between edges; checks the asynchronous effect immediately.
  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_select = 2'b01;
    bus.in_data   = '0;
    bus.out_ready = 3'b000;
    clear         = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_state("rst");
    check("rst in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit                iv;
    logic [1:0]        sel;
    logic [DATA_W-1:0] d;
    logic [2:0]        ordy;
    bit                clr;
    bit                exp_rdy;
    logic [2:0]        exp_valid;
    logic [CNT_W-1:0]  exp_drop;
    bit                exp_err;
    int                word_ch;
    logic [DATA_W-1:0] word;
  } vec_t;

  vec_t vecs [10];

  initial begin
    bit rdy;

    vecs[0] = '{1'b1, 2'd1, 24'hA5A5A5, 3'b000, 1'b0, 1'b1, 3'b010, 8'd0, 1'b0, 1, 24'hA5A5A5};
    vecs[1] = '{1'b0, 2'd1, 24'h000000, 3'b000, 1'b0, 1'b0, 3'b010, 8'd0, 1'b0, 1, 24'hA5A5A5};
    vecs[2] = '{1'b0, 2'd0, 24'h000000, 3'b000, 1'b0, 1'b1, 3'b010, 8'd0, 1'b0, -1, 24'h0};
    vecs[3] = '{1'b0, 2'd2, 24'h000000, 3'b000, 1'b0, 1'b1, 3'b010, 8'd0, 1'b0, -1, 24'h0};
    vecs[4] = '{1'b1, 2'd3, 24'h123456, 3'b000, 1'b0, 1'b1, 3'b010, 8'd1, 1'b1, -1, 24'h0};
    vecs[5] = '{1'b0, 2'd0, 24'h000000, 3'b000, 1'b1, 1'b1, 3'b010, 8'd0, 1'b0, -1, 24'h0};
    vecs[6] = '{1'b1, 2'd2, 24'h000001, 3'b000, 1'b0, 1'b1, 3'b110, 8'd0, 1'b0, 2, 24'h000001};
    vecs[7] = '{1'b1, 2'd2, 24'h000002, 3'b100, 1'b0, 1'b1, 3'b110, 8'd0, 1'b0, 2, 24'h000002};
    vecs[8] = '{1'b0, 2'd0, 24'h000000, 3'b010, 1'b0, 1'b1, 3'b100, 8'd0, 1'b0, 1, 24'hA5A5A5};
    vecs[9] = '{1'b0, 2'd0, 24'h000000, 3'b100, 1'b0, 1'b1, 3'b000, 8'd0, 1'b0, 2, 24'h000002};

    rst           = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_select = 2'b00;
    bus.in_data   = '0;
    bus.out_ready = 3'b000;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Table: routing, in_ready per select, drop/clear, pass-through drain.
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].iv, vecs[i].sel, vecs[i].d, vecs[i].ordy, vecs[i].clr, rdy);
      check($sformatf("vec%0d in_ready", i), rdy, vecs[i].exp_rdy);
      check($sformatf("vec%0d out_valid", i), bus.out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d drop_cnt", i), drop_cnt, vecs[i].exp_drop);
      check($sformatf("vec%0d sel_err", i), sel_err, vecs[i].exp_err);
      if (vecs[i].word_ch >= 0)
        check($sformatf("vec%0d word", i), data_of(vecs[i].word_ch), vecs[i].word);
    end
    check("table cnt_1", cnt_1, 8'd1);
    check("table cnt_2", cnt_2, 8'd2);

    // Back-to-back ch0 traffic with the destination always ready: saturation
    // and in-order delivery (pop_word checks each word against the queue).
    cycle(1'b0, 2'd0, '0, 3'b000, 1'b1, rdy);
    for (int i = 0; i < 300; i++)
      cycle(1'b1, 2'd0, DATA_W'($urandom), 3'b001, 1'b0, rdy);
    cycle(1'b0, 2'd0, '0, 3'b001, 1'b0, rdy);
    check("sat cnt_0", cnt_0, 8'd255);
    check("sat out_valid", bus.out_valid, 3'b000);

    // Clear coinciding with a pop and an invalid take.
    cycle(1'b1, 2'd1, 24'h00BEEF, 3'b000, 1'b0, rdy);
    cycle(1'b1, 2'd3, 24'h0F0F0F, 3'b010, 1'b1, rdy);
    check("clrwin cnt_1", cnt_1, 8'd0);
    check("clrwin drop_cnt", drop_cnt, 8'd0);
    check("clrwin sel_err", sel_err, 1'b0);

    // Fill all slots, then reset between edges; nothing may reappear afterwards.
    cycle(1'b1, 2'd0, 24'h111111, 3'b000, 1'b0, rdy);
    cycle(1'b1, 2'd1, 24'h222222, 3'b000, 1'b0, rdy);
    cycle(1'b1, 2'd2, 24'h333333, 3'b000, 1'b0, rdy);
    cycle(1'b1, 2'd3, 24'h444444, 3'b000, 1'b0, rdy);
    check("full out_valid", bus.out_valid, 3'b111);
    do_reset();
    cycle(1'b0, 2'd0, '0, 3'b000, 1'b0, rdy);
    check("post-rst out_valid", bus.out_valid, 3'b000);
    // First take right after reset release.
    cycle(1'b1, 2'd2, 24'h5A5A5A, 3'b000, 1'b0, rdy);
    check("post-rst take", bus.out_data_2, 24'h5A5A5A);

    // Randomized traffic against the model, with one mid-run reset.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset();
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), DATA_W'($urandom),
            3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0), rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_3_route.md
DEMUX_3_ROUTE -- requirements
Module: demux_3_route

Interface
REQ-001 DATA_W, 24, routed word width.
REQ-002 CNT_W, 8, width of each per-destination delivery counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  source offers a word this cycle.
REQ-006 in_ready  output  1  block accepts the offered word this cycle.
REQ-007 in_data  input  DATA_W  word to route.
REQ-008 in_select  input  2  destination: 00 -> ch0, 01 -> ch1, 10 -> ch2, 11 -> invalid.
REQ-009 out_valid  output  3  bit k: channel k holds a word.
REQ-010 out_ready  input  3  bit k: destination k takes the word this cycle.
REQ-011 out_data_0, out_data_1, out_data_2  output  DATA_W each  registered channel words.
REQ-012 cnt_0, cnt_1, cnt_2  output  CNT_W each  words delivered per channel.
REQ-013 drop_cnt  output  CNT_W  words accepted with in_select = 11.
REQ-014 sel_err  output  1  sticky flag, set by any invalid-select acceptance.
REQ-015 clear  input  1  synchronous clear of all counters and sel_err; buffered words are kept.

Function
REQ-016 Each channel SHALL hold one single-entry slot with two states: EMPTY and FULL.
REQ-017 Input accepted ("take") SHALL mean in_valid && in_ready on a rising edge.
REQ-018 Output k delivered ("pop_k") SHALL mean out_valid[k] && out_ready[k] on a rising edge.
REQ-019 in_ready for select k in 0..2 SHALL be computed combinationally as (slot k EMPTY) or (out_ready[k]), which is pass-through while draining.
REQ-020 in_ready for select 11 SHALL be 1; a take with select 11 SHALL discard the word, increment drop_cnt and set sel_err.
REQ-021 Slot k transitions:
- On take to k while EMPTY: load in_data and go FULL.
- On pop_k without a take to k: go EMPTY.
- On pop_k and a take to k in the same cycle: load the new word and stay FULL.
REQ-022 Latency SHALL be one cycle: a word taken at edge N appears on out_data_k with out_valid[k]=1 after edge N.
REQ-023 out_data_k SHALL stay stable while out_valid[k]=1 and out_ready[k]=0.
REQ-024 in_ready SHALL not depend on in_valid.
REQ-025 Only the selected channel's slot SHALL change on a take; non-selected slots SHALL keep their contents.
REQ-026 A pop on one channel SHALL be independent of takes to other channels in the same cycle.
REQ-027 cnt_k SHALL increment on each pop_k and saturate at 2^CNT_W-1.
REQ-028 drop_cnt SHALL saturate at 2^CNT_W-1.
REQ-029 When clear coincides with pop_k or an invalid take, clear SHALL win: the counter becomes 0 and sel_err becomes 0.
REQ-030 out_data_k SHALL retain its last value when EMPTY; consumers qualify it with out_valid.

Reset
REQ-031 rst=1 SHALL asynchronously set:
- all slots EMPTY and out_valid = 000
- out_data_0..2 = 0
- cnt_0..2 = 0, drop_cnt = 0, sel_err = 0
REQ-032 in_ready SHALL be 1 while rst=1.
REQ-033 Reset asserted mid-transfer SHALL discard all held words, with no pop counted.
REQ-034 The first take SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-035 A shared package SHALL hold DATA_W, CNT_W, the select encodings (SEL_CH0, SEL_CH1, SEL_CH2, SEL_BAD) and the slot state encoding (EMPTY, FULL).
REQ-036 The single-entry slot with its saturating delivery counter SHALL be a sub-module, route_slot, instantiated three times.
REQ-037 The top level SHALL contain only the select decode, the in_ready mux, the drop logic and sel_err.

Verification
REQ-038 Reset, then take 0xA5A5A5 with select 01 while out_ready=000.
- Required: next cycle out_valid=010 and out_data_1=0xA5A5A5.
- Required: in_ready is 0 for select 01 and 1 for selects 00 and 10.
REQ-039 Ch2 FULL holding 0x000001, with out_ready[2]=1 and in_valid=1, select 10, data 0x000002 in the same cycle.
- Required: cnt_2 increments by 1.
- Required: out_data_2=0x000002 and out_valid[2] stays 1.
REQ-040 Take 0x123456 with select 11.
- Required: out_valid unchanged, drop_cnt=1, sel_err=1.
- Then pulse clear: drop_cnt=0 and sel_err=0.
REQ-041 Hold out_ready[0]=1 and do 300 back-to-back takes to ch0.
- Required: cnt_0 saturates at 255 and every word emerges in order.
REQ-042 Fill all three slots, then assert rst for 1 ns between edges.
- Required: out_valid=000 immediately, all counters 0, no output change on the next edge without a take.
